// File: rtl/ysyx_041514_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_041514_mdu_ctrl
//
// Purpose:
//   Sequencing controller between the execute stage and the iterative
//   multiplier / divider units. It fires a one-cycle start pulse at the
//   selected unit and stalls the pipeline while the unit runs. It buffers the
//   returned result until the execute stage consumes it. A flushed op whose
//   unit is still busy is drained silently. An 8-bit watchdog abandons an op
//   whose unit never answers and raises a sticky error flag.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous reset, active low
//   req_valid_i    execute stage holds a mul/div op
//   req_sel_i      0 = multiply, 1 = divide/remainder
//   req_bypass_i   result resolved combinationally upstream, no unit start
//   flush_i        pipeline flush, discard the current op
//   ex_ready_i     execute stage consumes the buffered result this cycle
//   mul_valid_o    start pulse to the multiplier
//   mul_ready_i    multiplier result valid
//   mul_data_i     multiplier result
//   div_valid_o    start pulse to the divider
//   div_ready_i    divider result valid
//   div_data_i     divider result
//   buff_valid_o   buffered result valid
//   buff_data_o    buffered result
//   stall_req_o    pipeline stall request
//   busy_o         a unit operation is in flight
//   timeout_o      sticky watchdog error flag
// ---------------------------------------------------------------------------
module ysyx_041514_mdu_ctrl #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    input  logic            req_sel_i,
    input  logic            req_bypass_i,
    input  logic            flush_i,
    input  logic            ex_ready_i,
    output logic            mul_valid_o,
    input  logic            mul_ready_i,
    input  logic [XLEN-1:0] mul_data_i,
    output logic            div_valid_o,
    input  logic            div_ready_i,
    input  logic [XLEN-1:0] div_data_i,
    output logic            buff_valid_o,
    output logic [XLEN-1:0] buff_data_o,
    output logic            stall_req_o,
    output logic            busy_o,
    output logic            timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT);

    state_t          r_state;
    logic            r_sel;
    logic [7:0]      r_cnt;
    logic            r_buff_valid;
    logic [XLEN-1:0] r_buff_data;
    logic            r_timeout;

    logic            w_req_go;
    logic            w_start;
    logic            w_ready;
    logic [XLEN-1:0] w_data;
    logic [7:0]      w_cnt_next;
    logic            w_expire;

    // A request wants a unit only when it is neither resolved upstream nor
    // being flushed. The same term drives the stall in IDLE and DRAIN.
    assign w_req_go = req_valid_i & ~req_bypass_i & ~flush_i;

    // The start pulse has to appear in the very cycle the request is seen,
    // so it is decoded from the state register rather than registered.
    // Gating with rst keeps the units quiet while reset is applied.
    assign w_start     = rst & (r_state == S_IDLE) & w_req_go;
    assign mul_valid_o = w_start & ~req_sel_i;
    assign div_valid_o = w_start &  req_sel_i;

    // Only the unit that was started is listened to; the other unit's
    // handshake can be left over from an unrelated op and must not leak in.
    assign w_ready = r_sel ? div_ready_i : mul_ready_i;
    assign w_data  = r_sel ? div_data_i  : mul_data_i;

    // Watchdog count for the current cycle, saturating at the limit. The op
    // expires in the cycle this count lands on the limit, so a unit that
    // answers in that very cycle still wins.
    assign w_cnt_next = (r_cnt == LP_LIMIT) ? r_cnt : r_cnt + 8'd1;
    assign w_expire   = (w_cnt_next == LP_LIMIT);

    // While reset is held the stall follows the IDLE rule regardless of the
    // state register, since the controller is about to be IDLE anyway.
    // During DRAIN a new request must stall because it cannot start yet.
    assign stall_req_o = (!rst || r_state == S_IDLE || r_state == S_DRAIN)
                         ? w_req_go : (r_state == S_WAIT);
    assign busy_o       = (r_state == S_WAIT) || (r_state == S_DRAIN);
    assign buff_valid_o = r_buff_valid;
    assign buff_data_o  = r_buff_data;
    assign timeout_o    = r_timeout;

    // Main controller. IDLE launches an op and WAIT collects its result into
    // the buffer. HOLD presents the buffer until it is consumed or flushed.
    // DRAIN swallows the answer of an op that was flushed while running.
    // Leaving HOLD always passes through IDLE, so a new op can never start
    // in the cycle the previous result is consumed. A watchdog expiry in
    // WAIT or DRAIN abandons the op and latches the sticky error flag; it
    // takes precedence over a flush because the unit is considered hung.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_sel        <= 1'b0;
            r_cnt        <= 8'd0;
            r_buff_valid <= 1'b0;
            r_buff_data  <= '0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_go) begin
                        r_sel   <= req_sel_i;
                        r_cnt   <= 8'd0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_next;
                    if (w_ready) begin
                        if (flush_i) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_buff_data  <= w_data;
                            r_buff_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end
                    end else if (w_expire) begin
                        r_timeout    <= 1'b1;
                        r_buff_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (flush_i) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_DRAIN;
                    end
                end
                S_HOLD: begin
                    if (ex_ready_i || flush_i) begin
                        r_buff_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    r_cnt <= w_cnt_next;
                    if (w_ready) begin
                        r_state <= S_IDLE;
                    end else if (w_expire) begin
                        r_timeout    <= 1'b1;
                        r_buff_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_041514_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_041514_mdu_ctrl
//
// Purpose:
//   Scoreboard bench for the mul/div sequencing controller. The driver plays
//   the execute stage and both arithmetic units. For every transaction it
//   works out the expected timeline from the op parameters (latency, flush
//   point, hold length) and queues the expected per-cycle control outputs and
//   the expected buffered results. A monitor pops those queues on the falling
//   edge and compares them with what the controller presents.
// ---------------------------------------------------------------------------
module tb_ysyx_041514_mdu_ctrl;

    localparam int XLEN = 64;
    localparam int TMO  = 4;

    // {stall, busy, mul pulse, div pulse, buffer valid, timeout}
    typedef logic [5:0] ctrl_t;

    typedef struct {
        int    cyc;
        ctrl_t c;
    } ctrlExp_t;

    typedef struct {
        int              cyc;
        logic [XLEN-1:0] data;
    } resExp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid_i;
    logic            req_sel_i;
    logic            req_bypass_i;
    logic            flush_i;
    logic            ex_ready_i;
    logic            mul_valid_o;
    logic            mul_ready_i;
    logic [XLEN-1:0] mul_data_i;
    logic            div_valid_o;
    logic            div_ready_i;
    logic [XLEN-1:0] div_data_i;
    logic            buff_valid_o;
    logic [XLEN-1:0] buff_data_o;
    logic            stall_req_o;
    logic            busy_o;
    logic            timeout_o;

    ctrlExp_t        ctrlQ[$];
    resExp_t         resQ[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc    = 0;
    logic            expTmo = 1'b0;
    logic            prevBv = 1'b0;
    logic [XLEN-1:0] holdData = '0;

    ysyx_041514_mdu_ctrl #(
        .XLEN    (XLEN),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_sel_i    (req_sel_i),
        .req_bypass_i (req_bypass_i),
        .flush_i      (flush_i),
        .ex_ready_i   (ex_ready_i),
        .mul_valid_o  (mul_valid_o),
        .mul_ready_i  (mul_ready_i),
        .mul_data_i   (mul_data_i),
        .div_valid_o  (div_valid_o),
        .div_ready_i  (div_ready_i),
        .div_data_i   (div_data_i),
        .buff_valid_o (buff_valid_o),
        .buff_data_o  (buff_data_o),
        .stall_req_o  (stall_req_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    // Free-running clock and a cycle index shared by driver and monitor.
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic ctrl_t mk(input logic st, input logic bs, input logic mp,
                                 input logic dp, input logic bv);
        return {st, bs, mp, dp, bv, expTmo};
    endfunction

    function automatic logic [XLEN-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Drives one cycle of inputs just after the rising edge and, if asked,
    // queues the control outputs expected during that cycle.
    task automatic applyStimulus(input bit chk, input logic rs, input logic rv,
                                 input logic sl, input logic by, input logic fl,
                                 input logic exr, input logic mr,
                                 input logic [XLEN-1:0] md, input logic dr,
                                 input logic [XLEN-1:0] dd, input ctrl_t e);
        ctrlExp_t t;
        @(posedge clk);
        #1;
        rst          = rs;
        req_valid_i  = rv;
        req_sel_i    = sl;
        req_bypass_i = by;
        flush_i      = fl;
        ex_ready_i   = exr;
        mul_ready_i  = mr;
        mul_data_i   = md;
        div_ready_i  = dr;
        div_data_i   = dd;
        if (chk) begin
            t.cyc = cyc;
            t.c   = e;
            ctrlQ.push_back(t);
        end
    endtask

    task automatic pushResult(input int c, input logic [XLEN-1:0] d);
        resExp_t r;
        r.cyc  = c;
        r.data = d;
        resQ.push_back(r);
    endtask

    // Issue cycle: the selected unit gets its pulse and the pipeline stalls.
    // Unit handshakes are random here because IDLE must ignore them.
    task automatic issue(input logic sl);
        applyStimulus(1, 1, 1, sl, 0, 0, 0, 1'($urandom), rnd64(),
                      1'($urandom), rnd64(), mk(1, 0, !sl, sl, 0));
    endtask

    // Handshakes while an op runs: the started unit answers only in the
    // answer cycle, the other unit toggles randomly and must be ignored.
    task automatic unitCycle(input logic sl, input bit ans, input logic [XLEN-1:0] d,
                             output logic mr, output logic [XLEN-1:0] md,
                             output logic dr, output logic [XLEN-1:0] dd);
        mr = 1'($urandom);
        md = rnd64();
        dr = 1'($urandom);
        dd = rnd64();
        if (sl) begin
            dr = ans;
            if (ans) dd = d;
        end else begin
            mr = ans;
            if (ans) md = d;
        end
    endtask

    // Ordinary op: unit answers k cycles after the pulse, the result is held
    // for h+1 cycles and then consumed (or flushed away).
    task automatic runNormal(input logic sl, input int k, input int h,
                             input bit flushExit, input logic [XLEN-1:0] d);
        logic mr, dr;
        logic [XLEN-1:0] md, dd;
        issue(sl);
        for (int c = 1; c <= k; c++) begin
            unitCycle(sl, (c == k), d, mr, md, dr, dd);
            applyStimulus(1, 1, 1, sl, 0, 0, 0, mr, md, dr, dd, mk(1, 1, 0, 0, 0));
            if (c == k) pushResult(cyc + 1, d);
        end
        for (int c = 0; c <= h; c++) begin
            applyStimulus(1, 1, 1, sl, 1'($urandom), (c == h) && flushExit,
                          (c == h) && !flushExit, 1'($urandom), rnd64(),
                          1'($urandom), rnd64(), mk(0, 0, 0, 0, 1));
        end
    endtask

    // Flushed op: flush f cycles after the pulse, unit answers at k >= f.
    // Between the two the controller drains; new requests must stall.
    task automatic runFlush(input logic sl, input int f, input int k);
        logic mr, dr, rv, by, fl;
        logic [XLEN-1:0] md, dd;
        issue(sl);
        for (int c = 1; c <= f; c++) begin
            unitCycle(sl, (c == k), rnd64(), mr, md, dr, dd);
            applyStimulus(1, 1, 1, sl, 0, (c == f), 0, mr, md, dr, dd, mk(1, 1, 0, 0, 0));
        end
        for (int c = f + 1; c <= k; c++) begin
            unitCycle(sl, (c == k), rnd64(), mr, md, dr, dd);
            rv = 1'($urandom);
            by = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 3) == 0);
            applyStimulus(1, 1, rv, 1'($urandom), by, fl, 0, mr, md, dr, dd,
                          mk(rv & !by & !fl, 1, 0, 0, 0));
        end
    endtask

    // Unit never answers: after TMO busy cycles the op is dropped and the
    // error flag stays up from then on.
    task automatic runTimeout(input logic sl);
        logic mr, dr;
        logic [XLEN-1:0] md, dd;
        issue(sl);
        for (int c = 1; c <= TMO; c++) begin
            unitCycle(sl, 0, rnd64(), mr, md, dr, dd);
            applyStimulus(1, 1, 1, sl, 0, 0, 0, mr, md, dr, dd, mk(1, 1, 0, 0, 0));
        end
        expTmo = 1'b1;
    endtask

    // Idle cycle where no unit may start: no request, a bypassed request or
    // a flushed request. Unit handshakes are noise.
    task automatic runGap(input int mode);
        logic rv, by, fl;
        rv = (mode != 0);
        by = (mode == 1) || (mode == 3) || ((mode == 0) && 1'($urandom));
        fl = (mode == 2) || (mode == 3) || ((mode == 0) && 1'($urandom));
        applyStimulus(1, 1, rv, 1'($urandom), by, fl, 1'($urandom), 1'($urandom),
                      rnd64(), 1'($urandom), rnd64(), mk(0, 0, 0, 0, 0));
    endtask

    // Reset while an op is in flight; the late answer must be ignored.
    task automatic runResetMid(input logic sl);
        logic mr, dr;
        logic [XLEN-1:0] md, dd, d;
        d = rnd64();
        issue(sl);
        for (int c = 1; c <= 2; c++) begin
            unitCycle(sl, 0, d, mr, md, dr, dd);
            applyStimulus(1, 1, 1, sl, 0, 0, 0, mr, md, dr, dd, mk(1, 1, 0, 0, 0));
        end
        applyStimulus(0, 0, 0, sl, 0, 0, 0, 0, '0, 0, '0, '0);
        expTmo = 1'b0;
        unitCycle(sl, 1, d, mr, md, dr, dd);
        applyStimulus(1, 1, 0, sl, 0, 0, 0, mr, md, dr, dd, mk(0, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput("midResetData", buff_data_o, 64'h0);
    endtask

    task automatic runRandom(input int n);
        int kind, f, k;
        for (int i = 0; i < n; i++) begin
            kind = int'($urandom_range(0, 5));
            case (kind)
                0, 1, 2: runNormal(1'($urandom), int'($urandom_range(1, TMO)),
                                   int'($urandom_range(0, 3)),
                                   ($urandom_range(0, 3) == 0), rnd64());
                3: begin
                    f = int'($urandom_range(1, TMO - 1));
                    k = int'($urandom_range(f, f + TMO));
                    runFlush(1'($urandom), f, k);
                end
                default: runGap(int'($urandom_range(0, 3)));
            endcase
        end
    endtask

    // Monitor: pops the per-cycle expectation every falling edge and, when a
    // buffered result appears, pops and checks the result scoreboard.
    initial begin : monitor
        ctrlExp_t e;
        resExp_t  r;
        ctrl_t    act;
        forever begin
            @(negedge clk);
            act = {stall_req_o, busy_o, mul_valid_o, div_valid_o, buff_valid_o, timeout_o};
            if (ctrlQ.size() > 0) begin
                e = ctrlQ.pop_front();
                checkOutput("cycleTag", 64'(cyc), 64'(e.cyc));
                checkOutput("ctrl{stall,busy,mulV,divV,buffV,tmo}", 64'(act), 64'(e.c));
            end
            if (buff_valid_o === 1'b1 && prevBv !== 1'b1) begin
                if (resQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedResult at cycle %0d: got 0x%0h, expected no result",
                             cyc, buff_data_o);
                end else begin
                    r = resQ.pop_front();
                    checkOutput("resultCycle", 64'(cyc), 64'(r.cyc));
                    checkOutput("resultData", buff_data_o, r.data);
                    holdData = r.data;
                end
            end else if (buff_valid_o === 1'b1) begin
                checkOutput("holdData", buff_data_o, holdData);
            end
            prevBv = buff_valid_o;
        end
    end

    // Driver: reset, directed scenarios, random traffic, timeout, reset
    // mid-op, more random traffic, then drain and summarise.
    initial begin : driver
        rst          = 1'b0;
        req_valid_i  = 1'b1;
        req_sel_i    = 1'b0;
        req_bypass_i = 1'b0;
        flush_i      = 1'b0;
        ex_ready_i   = 1'b0;
        mul_ready_i  = 1'b0;
        mul_data_i   = '0;
        div_ready_i  = 1'b0;
        div_data_i   = '0;

        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, '0, 0, '0, '0);
        repeat (2) applyStimulus(1, 0, 1, 1'($urandom), 0, 0, 0, 1'($urandom),
                                 rnd64(), 1'($urandom), rnd64(), mk(1, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput("resetData", buff_data_o, 64'h0);

        runNormal(0, 3, 1, 0, 64'h1234);
        runGap(1);
        runGap(0);
        runNormal(1, 1, 0, 0, rnd64());
        runNormal(1, 2, 2, 1, rnd64());
        runFlush(1, 2, 6);
        runFlush(0, 2, 2);
        runNormal(0, TMO, 0, 0, rnd64());

        runRandom(150);

        runTimeout(1);
        runGap(0);
        runNormal(0, 2, 0, 0, rnd64());
        runRandom(30);

        runResetMid(1);
        runRandom(150);

        repeat (3) runGap(0);
        @(negedge clk);
        checkOutput("ctrlQueueDrained", 64'(ctrlQ.size()), 64'h0);
        checkOutput("resultQueueDrained", 64'(resQ.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_041514_mdu_ctrl.md
YSYX_041514_MDU_CTRL -- requirements
Module: ysyx_041514_mdu_ctrl

Interface
REQ-001 Parameter XLEN, default 64: result data width.
REQ-002 Parameter TIMEOUT, default 255, range 2..255: watchdog limit in cycles.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 req_valid_i  in  1  execute stage holds a mul/div op.
REQ-006 req_sel_i  in  1  0 = multiply, 1 = divide/remainder.
REQ-007 req_bypass_i  in  1  result resolved combinationally (div-by-zero/overflow check); no unit start.
REQ-008 flush_i  in  1  pipeline flush; discard the current op.
REQ-009 ex_ready_i  in  1  execute stage consumes the buffered result this cycle.
REQ-010 mul_valid_o  out  1  one-cycle start pulse to the multiplier.
REQ-011 mul_ready_i  in  1  multiplier result valid.
REQ-012 mul_data_i  in  XLEN  selected multiplier result.
REQ-013 div_valid_o  out  1  one-cycle start pulse to the divider.
REQ-014 div_ready_i  in  1  divider result valid.
REQ-015 div_data_i  in  XLEN  selected divider result.
REQ-016 buff_valid_o  out  1  buffered result valid.
REQ-017 buff_data_o  out  XLEN  buffered result.
REQ-018 stall_req_o  out  1  request to stall the pipeline.
REQ-019 busy_o  out  1  a unit operation is in flight.
REQ-020 timeout_o  out  1  sticky watchdog error flag.

Function
REQ-021 FSM states: IDLE, WAIT (unit running), HOLD (result buffered), DRAIN (flushed op still in flight).
REQ-022 IDLE, req_valid_i=1, req_bypass_i=0, flush_i=0: pulse mul_valid_o (sel=0) or div_valid_o (sel=1) that cycle; latch sel; go to WAIT.
REQ-023 IDLE with req_bypass_i=1 or flush_i=1: no start pulse; stay in IDLE.
REQ-024 stall_req_o = req_valid_i & ~req_bypass_i & ~flush_i in IDLE; 1 in WAIT; 0 in HOLD.
REQ-025 In DRAIN, stall_req_o = req_valid_i & ~req_bypass_i & ~flush_i; a new op is never started while in DRAIN.
REQ-026 WAIT: only the ready input of the latched unit is honored; the other unit's ready is ignored.
REQ-027 WAIT with latched ready=1 and flush_i=0: capture the matching data into buff_data_o; set buff_valid_o next cycle; go to HOLD.
REQ-028 WAIT with flush_i=1 and ready=0: go to DRAIN. WAIT with flush_i=1 and ready=1: discard the data; go to IDLE.
REQ-029 HOLD: buff_valid_o=1 and buff_data_o stable; on ex_ready_i=1 or flush_i=1, clear buff_valid_o and go to IDLE the next cycle.
REQ-030 A new op never starts in the same cycle the controller leaves HOLD; minimum issue spacing is one IDLE cycle.
REQ-031 DRAIN: on ready of the latched unit, go to IDLE with buffer unchanged and buff_valid_o=0.
REQ-032 busy_o=1 in WAIT and DRAIN, else 0.
REQ-033 Start pulses last exactly one cycle, and at most one of mul_valid_o and div_valid_o is high in any cycle.
REQ-034 Watchdog counter (8 bits):
  - cleared on entering WAIT or DRAIN;
  - increments each cycle in WAIT or DRAIN;
  - saturates at TIMEOUT.
REQ-035 On counter reaching TIMEOUT without ready: set timeout_o=1 (sticky until reset); clear buff_valid_o; go to IDLE the next cycle.
REQ-036 Latency: start pulse at cycle N, unit ready at cycle N+k gives buff_valid_o=1 at cycle N+k+1.

Reset
REQ-037 While rst=0 at a clock edge:
  - state=IDLE;
  - buff_valid_o=0, buff_data_o=0, timeout_o=0, busy_o=0;
  - start pulses 0; counter 0.
REQ-038 Reset mid-operation abandons the in-flight op; a later unit ready is ignored in IDLE.
REQ-039 stall_req_o in reset follows REQ-024 for IDLE.

Verification
REQ-040 Mul: req sel=0 at cycle 0, mul_ready_i=1 with 0x1234 at cycle 3
  - mul_valid_o pulse at cycle 0 only; stall 0..3;
  - buff_valid_o=1 with 0x1234 at cycle 4;
  - ex_ready_i at cycle 5 gives IDLE at cycle 6.
REQ-041 Bypass: req_valid_i=1 with req_bypass_i=1 -> no start pulse, stall_req_o=0, state stays IDLE.
REQ-042 Flush in WAIT: div started at cycle 0, flush_i at cycle 2, div_ready_i at cycle 6 -> DRAIN at cycle 3..6, buff_valid_o never set, IDLE at cycle 7.
REQ-043 New req during DRAIN -> stall_req_o=1 and no start pulse until IDLE, then start in the first IDLE cycle.
REQ-044 TIMEOUT=4, unit never ready -> timeout_o=1 after 4 WAIT cycles, return to IDLE, timeout_o held until rst=0.
REQ-045 Wrong-unit ready: div in flight and mul_ready_i=1 -> ignored; stays WAIT.
